tx_queue_arbiter: RTL and testbench

- Shares the single high-layer tx datapath (descriptor/TSF/payload FIFO read port) between NUM_QUEUE per-priority tx queues.
- Sits between the per-queue s_axis FIFOs and the tx bit interface.
- Presents one virtual queue (muxed dmg/tsf/data plus flags) and routes ask pulses back to the granted queue.
- Holds the grant for a whole packet: from descriptor fetch until the packet-done pulse, or until the watchdog expires.

---
 rtl/tx_queue_arbiter_pkg.sv | 19 +
 rtl/tx_queue_arbiter_if.sv | 44 ++++
 rtl/tx_queue_rr_pick.sv | 38 +++
 rtl/tx_queue_arbiter.sv | 167 ++++++++++++++++
 tb/tb_tx_queue_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_queue_arbiter_pkg.sv
// Shared definitions for the tx queue arbiter: state encoding, default
// queue geometry and small helpers used by the arbiter and its picker.
package tx_queue_arbiter_pkg;

  localparam int NUM_QUEUE_DEF = 4;
  localparam int QW_DEF        = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  // A queue owns the shared datapath while it is granted or locked.
  function automatic logic is_active(input arb_state_t st);
    return (st == ST_GRANT) || (st == ST_LOCKED);
  endfunction

endpackage

// File: rtl/tx_queue_arbiter_if.sv
// Bundles the per-queue FIFO heads/strobes and the tx bit interface side
// of the shared high-layer datapath. The arbiter takes the master view.
interface tx_queue_arbiter_if #(
  parameter int NUM_QUEUE       = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int TSF_TIMER_WIDTH = 64
);

  // per-queue FIFO side
  logic [NUM_QUEUE-1:0]                 empty_dmg_q;
  logic [NUM_QUEUE-1:0]                 emptyn_data_q;
  logic [NUM_QUEUE*DATA_WIDTH-1:0]      dmg_q;
  logic [NUM_QUEUE*TSF_TIMER_WIDTH-1:0] tsf_q;
  logic [NUM_QUEUE*DATA_WIDTH-1:0]      data_q;
  logic [NUM_QUEUE-1:0]                 ask_dmg_q;
  logic [NUM_QUEUE-1:0]                 ask_tsf_q;
  logic [NUM_QUEUE-1:0]                 ask_data_q;

  // virtual queue seen by the tx bit interface
  logic                       empty_dmg_to_tx;
  logic                       emptyn_data_to_tx;
  logic [DATA_WIDTH-1:0]      dmg_to_tx;
  logic [TSF_TIMER_WIDTH-1:0] tsf_to_tx;
  logic [DATA_WIDTH-1:0]      data_to_tx;
  logic                       ask_dmg_from_tx;
  logic                       ask_tsf_from_tx;
  logic                       ask_data_from_tx;
  logic                       pkt_done;

  modport master (
    input  empty_dmg_q, emptyn_data_q, dmg_q, tsf_q, data_q,
    output ask_dmg_q, ask_tsf_q, ask_data_q,
    output empty_dmg_to_tx, emptyn_data_to_tx, dmg_to_tx, tsf_to_tx, data_to_tx,
    input  ask_dmg_from_tx, ask_tsf_from_tx, ask_data_from_tx, pkt_done
  );

  modport slave (
    output empty_dmg_q, emptyn_data_q, dmg_q, tsf_q, data_q,
    input  ask_dmg_q, ask_tsf_q, ask_data_q,
    input  empty_dmg_to_tx, emptyn_data_to_tx, dmg_to_tx, tsf_to_tx, data_to_tx,
    output ask_dmg_from_tx, ask_tsf_from_tx, ask_data_from_tx, pkt_done
  );

endinterface

// File: rtl/tx_queue_rr_pick.sv
// Combinational winner selection among requesting queues: either the
// highest requesting index, or the first requester at/after rr_ptr.
module tx_queue_rr_pick
  import tx_queue_arbiter_pkg::*;
#(
  parameter int NUM_QUEUE = NUM_QUEUE_DEF,
  parameter int QW        = QW_DEF
) (
  input  logic [NUM_QUEUE-1:0] req,
  input  logic [QW-1:0]        rr_ptr,
  input  logic                 strict_prio,
  output logic [QW-1:0]        winner,
  output logic                 valid
);

  logic [QW-1:0] strict_win_s;
  logic [QW-1:0] rr_win_s;
  logic [QW-1:0] idx_s;

  // Scan both policies; later loop iterations override earlier ones so the
  // strict scan ends on the highest index and the rr scan on the nearest.
  always_comb begin
    strict_win_s = '0;
    rr_win_s     = '0;
    idx_s        = '0;
    for (int i = 0; i < NUM_QUEUE; i++) begin
      strict_win_s = req[i] ? QW'(i) : strict_win_s;
    end
    // NUM_QUEUE is a power of two, so QW-bit addition wraps modulo NUM_QUEUE.
    for (int k = NUM_QUEUE - 1; k >= 0; k--) begin
      idx_s    = rr_ptr + QW'(k);
      rr_win_s = req[idx_s] ? idx_s : rr_win_s;
    end
    winner = strict_prio ? strict_win_s : rr_win_s;
    valid  = |req;
  end

endmodule

// File: rtl/tx_queue_arbiter.sv
// Shares the single tx datapath between NUM_QUEUE priority queues. A queue
// is granted on a non-empty descriptor FIFO, locked at the descriptor
// fetch, and released on pkt_done or on watchdog expiry.
module tx_queue_arbiter
  import tx_queue_arbiter_pkg::*;
#(
  parameter int NUM_QUEUE       = NUM_QUEUE_DEF,
  parameter int QW              = QW_DEF,
  parameter int DATA_WIDTH      = 64,
  parameter int TSF_TIMER_WIDTH = 64,
  parameter int WDOG_WIDTH      = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_QUEUE-1:0]    queue_en,
  input  logic                    strict_prio,
  input  logic [WDOG_WIDTH-1:0]   wdog_top,
  tx_queue_arbiter_if.master      bus,
  output logic [QW-1:0]           cur_queue,
  output logic                    busy,
  output logic                    wdog_fire,
  output logic [NUM_QUEUE*32-1:0] grant_cnt
);

  arb_state_t                  state_r;
  arb_state_t                  state_nxt_s;
  logic [QW-1:0]               cur_queue_r;
  logic [QW-1:0]               cur_queue_nxt_s;
  logic [QW-1:0]               rr_ptr_r;
  logic [QW-1:0]               rr_ptr_nxt_s;
  logic [WDOG_WIDTH-1:0]       wdog_cnt_r;
  logic [WDOG_WIDTH-1:0]       wdog_cnt_nxt_s;
  logic                        wdog_fire_r;
  logic [NUM_QUEUE-1:0][31:0]  grant_cnt_r;

  logic [NUM_QUEUE-1:0]        req_s;
  logic [QW-1:0]               pick_winner_s;
  logic                        pick_valid_s;
  logic                        active_s;
  logic                        wdog_expire_s;
  logic                        done_s;
  logic                        wdog_hit_s;

  assign req_s    = ~bus.empty_dmg_q & queue_en;
  assign active_s = is_active(state_r);

  // The counter has already spent wdog_cnt_r cycles in LOCKED; expiry is the
  // cycle on which the incremented count would reach the programmed limit.
  assign wdog_expire_s = (wdog_top != '0) && ((wdog_cnt_r + WDOG_WIDTH'(1)) == wdog_top);

  tx_queue_rr_pick #(
    .NUM_QUEUE (NUM_QUEUE),
    .QW        (QW)
  ) u_pick (
    .req         (req_s),
    .rr_ptr      (rr_ptr_r),
    .strict_prio (strict_prio),
    .winner      (pick_winner_s),
    .valid       (pick_valid_s)
  );

  // Next-state logic for the grant FSM, rr pointer and watchdog counter.
  always_comb begin
    state_nxt_s     = state_r;
    cur_queue_nxt_s = cur_queue_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    wdog_cnt_nxt_s  = wdog_cnt_r;
    done_s          = 1'b0;
    wdog_hit_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s     = ST_GRANT;
          cur_queue_nxt_s = pick_winner_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A descriptor read has already been routed to the queue this cycle,
        // so the fetch takes precedence over a concurrent disable/empty.
        if (bus.ask_dmg_from_tx) begin
          state_nxt_s    = ST_LOCKED;
          wdog_cnt_nxt_s = '0;
          rr_ptr_nxt_s   = cur_queue_r + QW'(1);
        end else if (bus.empty_dmg_q[cur_queue_r] || !queue_en[cur_queue_r]) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_LOCKED: begin
        if (bus.pkt_done) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (wdog_expire_s) begin
          wdog_hit_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          wdog_cnt_nxt_s = wdog_cnt_r + WDOG_WIDTH'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Grant FSM state, granted queue, rr pointer, watchdog and its pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cur_queue_r <= '0;
      rr_ptr_r    <= '0;
      wdog_cnt_r  <= '0;
      wdog_fire_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cur_queue_r <= cur_queue_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      wdog_cnt_r  <= wdog_cnt_nxt_s;
      wdog_fire_r <= wdog_hit_s;
    end
  end

  // Per-queue completed-grant counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_r <= '0;
    end else if (done_s) begin
      grant_cnt_r[cur_queue_r] <= grant_cnt_r[cur_queue_r] + 32'd1;
    end else begin
      grant_cnt_r <= grant_cnt_r;
    end
  end

  // Zero-latency AND-OR muxes and strobe routing keyed on the granted queue;
  // everything is forced quiet while no queue owns the datapath.
  always_comb begin
    bus.dmg_to_tx         = '0;
    bus.tsf_to_tx         = '0;
    bus.data_to_tx        = '0;
    bus.emptyn_data_to_tx = 1'b0;
    bus.ask_dmg_q         = '0;
    bus.ask_tsf_q         = '0;
    bus.ask_data_q        = '0;
    for (int i = 0; i < NUM_QUEUE; i++) begin
      logic sel;
      sel = active_s && (QW'(i) == cur_queue_r);
      bus.dmg_to_tx         = bus.dmg_to_tx  | ({DATA_WIDTH{sel}} & bus.dmg_q[i*DATA_WIDTH +: DATA_WIDTH]);
      bus.tsf_to_tx         = bus.tsf_to_tx  | ({TSF_TIMER_WIDTH{sel}} & bus.tsf_q[i*TSF_TIMER_WIDTH +: TSF_TIMER_WIDTH]);
      bus.data_to_tx        = bus.data_to_tx | ({DATA_WIDTH{sel}} & bus.data_q[i*DATA_WIDTH +: DATA_WIDTH]);
      bus.emptyn_data_to_tx = bus.emptyn_data_to_tx | (sel & bus.emptyn_data_q[i]);
      bus.ask_dmg_q[i]      = sel & bus.ask_dmg_from_tx;
      bus.ask_tsf_q[i]      = sel & bus.ask_tsf_from_tx;
      bus.ask_data_q[i]     = sel & bus.ask_data_from_tx;
    end
    // Only GRANT exposes a descriptor; LOCKED hides it to block a second fetch.
    bus.empty_dmg_to_tx = (state_r == ST_GRANT) ? bus.empty_dmg_q[cur_queue_r] : 1'b1;
  end

  assign cur_queue = cur_queue_r;
  assign busy      = active_s;
  assign wdog_fire = wdog_fire_r;
  assign grant_cnt = grant_cnt_r;

endmodule

// File: tb/tb_tx_queue_arbiter.sv
// Directed self-checking bench for tx_queue_arbiter.
module tb_tx_queue_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   queue_en;
  logic         strict_prio;
  logic [19:0]  wdog_top;
  logic [1:0]   cur_queue;
  logic         busy;
  logic         wdog_fire;
  logic [127:0] grant_cnt;

  int n_cmp;
  int n_bad;

  tx_queue_arbiter_if #(.NUM_QUEUE(4), .DATA_WIDTH(64), .TSF_TIMER_WIDTH(64)) bus ();

  tx_queue_arbiter #(
    .NUM_QUEUE(4), .QW(2), .DATA_WIDTH(64), .TSF_TIMER_WIDTH(64), .WDOG_WIDTH(20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .queue_en    (queue_en),
    .strict_prio (strict_prio),
    .wdog_top    (wdog_top),
    .bus         (bus),
    .cur_queue   (cur_queue),
    .busy        (busy),
    .wdog_fire   (wdog_fire),
    .grant_cnt   (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for a grant, then runs one descriptor fetch + pkt_done.
  task automatic do_packet(output logic [1:0] q, output logic to);
    to = 1'b1;
    q  = 2'd0;
    for (int i = 0; i < 10; i++) begin
      if (busy) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    if (!to) begin
      q = cur_queue;
      bus.ask_dmg_from_tx = 1'b1;
      tick();
      bus.ask_dmg_from_tx = 1'b0;
      bus.pkt_done = 1'b1;
      tick();
      bus.pkt_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    n_cmp++; if (cur_queue !== 2'd0) begin n_bad++; $display("FAIL rst_cur: got %0d expected 0", cur_queue); end
    n_cmp++; if (bus.empty_dmg_to_tx !== 1'b1 || bus.emptyn_data_to_tx !== 1'b0) begin n_bad++; $display("FAIL rst_empty: got %0b/%0b expected 1/0", bus.empty_dmg_to_tx, bus.emptyn_data_to_tx); end
    n_cmp++; if (bus.dmg_to_tx !== 64'd0 || bus.tsf_to_tx !== 64'd0 || bus.data_to_tx !== 64'd0) begin n_bad++; $display("FAIL rst_mux: got %h expected 0", bus.dmg_to_tx); end
    n_cmp++; if (grant_cnt !== 128'd0 || wdog_fire !== 1'b0) begin n_bad++; $display("FAIL rst_cnt: got %h expected 0", grant_cnt); end
    // strobes and pkt_done while idle must be dropped
    bus.ask_dmg_from_tx = 1'b1;
    bus.ask_data_from_tx = 1'b1;
    bus.pkt_done = 1'b1;
    #1;
    n_cmp++; if (bus.ask_dmg_q !== 4'b0000 || bus.ask_data_q !== 4'b0000) begin n_bad++; $display("FAIL idle_ask: got %b expected 0000", bus.ask_dmg_q); end
    tick();
    bus.ask_dmg_from_tx = 1'b0;
    bus.ask_data_from_tx = 1'b0;
    bus.pkt_done = 1'b0;
    n_cmp++; if (grant_cnt !== 128'd0) begin n_bad++; $display("FAIL idle_pktdone: got %h expected 0", grant_cnt); end
  endtask

  task automatic test_strict();
    do_reset();
    strict_prio = 1'b1;
    queue_en = 4'b1111;
    bus.emptyn_data_q = 4'b0110;
    bus.empty_dmg_q = 4'b1001;
    tick();
    n_cmp++; if (cur_queue !== 2'd2 || busy !== 1'b1) begin n_bad++; $display("FAIL strict_cur: got %0d expected 2", cur_queue); end
    n_cmp++; if (bus.empty_dmg_to_tx !== 1'b0) begin n_bad++; $display("FAIL strict_empty: got %0b expected 0", bus.empty_dmg_to_tx); end
    n_cmp++; if (bus.dmg_to_tx !== 64'hD0D0_0000_0000_0002 || bus.tsf_to_tx !== 64'h7500_0000_0000_0002 || bus.data_to_tx !== 64'hDA7A_0000_0000_0002) begin n_bad++; $display("FAIL strict_mux: got %h expected d0d0000000000002", bus.dmg_to_tx); end
    bus.ask_dmg_from_tx = 1'b1;
    #1;
    n_cmp++; if (bus.ask_dmg_q !== 4'b0100) begin n_bad++; $display("FAIL strict_askdmg: got %b expected 0100", bus.ask_dmg_q); end
    tick();
    bus.ask_dmg_from_tx = 1'b0;
    bus.ask_data_from_tx = 1'b1;
    bus.ask_tsf_from_tx = 1'b1;
    #1;
    n_cmp++; if (bus.ask_data_q !== 4'b0100 || bus.ask_tsf_q !== 4'b0100) begin n_bad++; $display("FAIL locked_ask: got %b expected 0100", bus.ask_data_q); end
    n_cmp++; if (bus.empty_dmg_to_tx !== 1'b1 || bus.emptyn_data_to_tx !== 1'b1) begin n_bad++; $display("FAIL locked_empty: got %0b/%0b expected 1/1", bus.empty_dmg_to_tx, bus.emptyn_data_to_tx); end
    bus.ask_data_from_tx = 1'b0;
    bus.ask_tsf_from_tx = 1'b0;
    bus.empty_dmg_q = 4'b1111;
    bus.pkt_done = 1'b1;
    tick();
    bus.pkt_done = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL strict_idle: got %0b expected 0", busy); end
    n_cmp++; if (grant_cnt !== {32'd0, 32'd1, 32'd0, 32'd0}) begin n_bad++; $display("FAIL strict_cnt: got %h expected q2=1", grant_cnt); end
  endtask

  task automatic test_round_robin();
    logic [1:0] q;
    logic       to;
    do_reset();
    strict_prio = 1'b0;
    queue_en = 4'b1111;
    bus.empty_dmg_q = 4'b0000;
    for (int p = 0; p < 8; p++) begin
      do_packet(q, to);
      n_cmp++; if (to !== 1'b0 || q !== 2'(p % 4)) begin n_bad++; $display("FAIL rr_order%0d: got %0d expected %0d", p, q, p % 4); end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (grant_cnt[i*32 +: 32] !== 32'd2) begin n_bad++; $display("FAIL rr_cnt%0d: got %0d expected 2", i, grant_cnt[i*32 +: 32]); end
    end
  endtask

  task automatic test_queue_en_mask();
    logic [1:0] q;
    logic       to;
    do_reset();
    strict_prio = 1'b1;
    queue_en = 4'b1011;
    bus.empty_dmg_q = 4'b0000;
    do_packet(q, to);
    n_cmp++; if (to !== 1'b0 || q !== 2'd3) begin n_bad++; $display("FAIL mask_first: got %0d expected 3", q); end
    do_packet(q, to);
    n_cmp++; if (to !== 1'b0 || q !== 2'd3) begin n_bad++; $display("FAIL mask_second: got %0d expected 3", q); end
    queue_en = 4'b0011;
    do_packet(q, to);
    n_cmp++; if (to !== 1'b0 || q !== 2'd1) begin n_bad++; $display("FAIL mask_low: got %0d expected 1", q); end
    n_cmp++; if (grant_cnt !== {32'd2, 32'd0, 32'd1, 32'd0}) begin n_bad++; $display("FAIL mask_cnt: got %h expected q3=2 q1=1", grant_cnt); end
  endtask

  task automatic test_grant_abort();
    do_reset();
    strict_prio = 1'b1;
    queue_en = 4'b1111;
    bus.empty_dmg_q = 4'b0111;
    tick();
    n_cmp++; if (busy !== 1'b1 || cur_queue !== 2'd3) begin n_bad++; $display("FAIL abort_grant: got %0d expected 3", cur_queue); end
    bus.empty_dmg_q = 4'b1111;
    tick();
    n_cmp++; if (busy !== 1'b0 || grant_cnt !== 128'd0) begin n_bad++; $display("FAIL abort_idle: got %0b expected 0", busy); end
  endtask

  task automatic test_watchdog();
    int   n;
    logic fired;
    do_reset();
    strict_prio = 1'b1;
    queue_en = 4'b1111;
    wdog_top = 20'd100;
    bus.empty_dmg_q = 4'b1110;
    tick();
    n_cmp++; if (busy !== 1'b1 || cur_queue !== 2'd0) begin n_bad++; $display("FAIL wdog_grant: got %0d expected 0", cur_queue); end
    bus.ask_dmg_from_tx = 1'b1;
    tick();
    bus.ask_dmg_from_tx = 1'b0;
    n = 0;
    fired = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      n++;
      if (wdog_fire) begin
        fired = 1'b1;
        break;
      end
    end
    n_cmp++; if (fired !== 1'b1 || n !== 100) begin n_bad++; $display("FAIL wdog_cycles: got %0d expected 100", n); end
    n_cmp++; if (grant_cnt !== 128'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL wdog_nocount: got %h expected 0", grant_cnt); end
    tick();
    n_cmp++; if (wdog_fire !== 1'b0 || busy !== 1'b1 || cur_queue !== 2'd0) begin n_bad++; $display("FAIL wdog_rearb: got fire=%0b busy=%0b expected 0/1", wdog_fire, busy); end
  endtask

  task automatic test_done_vs_wdog();
    logic fired;
    // continues from the re-grant of queue 0 left by test_watchdog
    wdog_top = 20'd10;
    bus.ask_dmg_from_tx = 1'b1;
    tick();
    bus.ask_dmg_from_tx = 1'b0;
    fired = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      fired = fired | wdog_fire;
    end
    n_cmp++; if (fired !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL tie_early: got fire=%0b expected 0", fired); end
    bus.pkt_done = 1'b1;
    tick();
    bus.pkt_done = 1'b0;
    n_cmp++; if (wdog_fire !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL tie_fire: got %0b expected 0", wdog_fire); end
    n_cmp++; if (grant_cnt !== {32'd0, 32'd0, 32'd0, 32'd1}) begin n_bad++; $display("FAIL tie_cnt: got %h expected q0=1", grant_cnt); end
    wdog_top = 20'd0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] q;
    logic       to;
    int         n;
    do_reset();
    strict_prio = 1'b0;
    queue_en = 4'b1111;
    bus.empty_dmg_q = 4'b1011;
    do_packet(q, to);
    n_cmp++; if (to !== 1'b0 || q !== 2'd2) begin n_bad++; $display("FAIL b2b_first: got %0d expected 2", q); end
    n = 0;
    while (!busy && n < 5) begin
      tick();
      n++;
    end
    n_cmp++; if (n !== 1 || cur_queue !== 2'd2) begin n_bad++; $display("FAIL b2b_regrant: got %0d cycles expected 1", n); end
  endtask

  task automatic test_reset_mid_packet();
    logic [1:0] q;
    logic       to;
    do_reset();
    strict_prio = 1'b1;
    queue_en = 4'b1111;
    bus.empty_dmg_q = 4'b1101;
    do_packet(q, to);
    n_cmp++; if (to !== 1'b0 || grant_cnt !== {32'd0, 32'd0, 32'd1, 32'd0}) begin n_bad++; $display("FAIL midrst_pre: got %h expected q1=1", grant_cnt); end
    tick();
    bus.ask_dmg_from_tx = 1'b1;
    tick();
    bus.ask_dmg_from_tx = 1'b0;
    n_cmp++; if (busy !== 1'b1 || cur_queue !== 2'd1) begin n_bad++; $display("FAIL midrst_locked: got %0d expected 1", cur_queue); end
    bus.ask_data_from_tx = 1'b1;
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.ask_data_q !== 4'b0000 || bus.empty_dmg_to_tx !== 1'b1) begin n_bad++; $display("FAIL midrst_ask: got %b expected 0000", bus.ask_data_q); end
    n_cmp++; if (grant_cnt !== 128'd0 || busy !== 1'b0 || cur_queue !== 2'd0 || wdog_fire !== 1'b0) begin n_bad++; $display("FAIL midrst_state: got %h expected 0", grant_cnt); end
    rst = 1'b0;
    bus.ask_data_from_tx = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    queue_en = 4'b1111;
    strict_prio = 1'b1;
    wdog_top = 20'd0;
    bus.empty_dmg_q = 4'b1111;
    bus.emptyn_data_q = 4'b0000;
    bus.ask_dmg_from_tx = 1'b0;
    bus.ask_tsf_from_tx = 1'b0;
    bus.ask_data_from_tx = 1'b0;
    bus.pkt_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.dmg_q[i*64 +: 64]  = 64'hD0D0_0000_0000_0000 | 64'(i);
      bus.tsf_q[i*64 +: 64]  = 64'h7500_0000_0000_0000 | 64'(i);
      bus.data_q[i*64 +: 64] = 64'hDA7A_0000_0000_0000 | 64'(i);
    end
    test_reset();
    test_strict();
    test_round_robin();
    test_queue_en_mask();
    test_grant_abort();
    test_watchdog();
    test_done_vs_wdog();
    test_back_to_back();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
